// File: rtl/bip_pkg.sv
// Shared BIP definitions: opcode map, ACC source encodings, FSM states and
// the EXEC-cycle control bundle.
package bip_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_BGT  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_BGE  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_BLE  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_CALL = 5'b10000;
  localparam logic [OPC_W-1:0] OP_RET  = 5'b10001;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       wrpc;
    logic [1:0] sela;
    logic       selb;
    logic       wracc;
    logic       op;
    logic       wrram;
    logic       ret;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/bip_ret_stack.sv
// Hardware return-address LIFO. Overflowing pushes and underflowing pops are
// ignored here; the control unit treats them as faults.
module bip_ret_stack #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - 1'b1);
  assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = empty_o ? '0 : mem[rd_idx];

  always_ff @(posedge clock_i) begin
    if (!reset_n_i)
      sp_q <= '0;
    else if (push_i && !full_o)
      sp_q <= sp_q + 1'b1;
    else if (pop_i && !empty_o)
      sp_q <= sp_q - 1'b1;
  end

  // Entries need no reset: they are only visible through sp_q.
  always_ff @(posedge clock_i) begin
    if (push_i && !full_o)
      mem[wr_idx] <= data_i;
  end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle BIP control unit: FETCH latches opcode and flags, EXEC drives
// one cycle of datapath controls, HALT is sticky until reset.
import bip_pkg::*;

module bip_control_unit #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic              n_i,
  input  logic              z_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  output logic              branch_o,
  output logic              wrpc_o,
  output logic [1:0]        sela_o,
  output logic              selb_o,
  output logic              wracc_o,
  output logic              op_o,
  output logic              wrram_o,
  output logic              ret_o,
  output logic [ADDR_W-1:0] stack_top_o,
  output logic              halted_o,
  output logic              illegal_o,
  output logic              stack_err_o
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] ir_q;
  logic             n_q, z_q, err_q;
  logic             push, pop, fault, full, empty;
  ctrl_t            ctrl;

  bip_ret_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .pop_i     (pop),
    .data_i    (pc_next_i),
    .top_o     (stack_top_o),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) begin
        ir_q <= opcode_i;
        n_q  <= n_i;
        z_q  <= z_i;
      end
      if (fault) err_q <= 1'b1;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    fault   = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d   = ST_FETCH;
        ctrl.wrpc = 1'b1;
        case (ir_q)
          OP_HLT: begin
            ctrl.wrpc = 1'b0;
            state_d   = ST_HALT;
          end
          OP_STO: ctrl.wrram = 1'b1;
          OP_LD: begin
            ctrl.wracc = 1'b1;
            ctrl.sela  = SELA_MEM;
          end
          OP_LDI: begin
            ctrl.wracc = 1'b1;
            ctrl.sela  = SELA_IMM;
          end
          // bit0 picks the immediate operand, bit1 picks subtract
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            ctrl.wracc = 1'b1;
            ctrl.sela  = SELA_ALU;
            ctrl.selb  = ir_q[0];
            ctrl.op    = ir_q[1];
          end
          OP_BEQ: ctrl.branch = z_q;
          OP_BNE: ctrl.branch = !z_q;
          OP_BGT: ctrl.branch = !n_q && !z_q;
          OP_BGE: ctrl.branch = !n_q;
          OP_BLT: ctrl.branch = n_q;
          OP_BLE: ctrl.branch = n_q || z_q;
          OP_JMP: ctrl.branch = 1'b1;
          OP_CALL: begin
            if (full) begin
              ctrl.wrpc = 1'b0;
              fault     = 1'b1;
              state_d   = ST_HALT;
            end else begin
              ctrl.branch = 1'b1;
              push        = 1'b1;
            end
          end
          OP_RET: begin
            if (empty) begin
              ctrl.wrpc = 1'b0;
              fault     = 1'b1;
              state_d   = ST_HALT;
            end else begin
              ctrl.ret = 1'b1;
              pop      = 1'b1;
            end
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  assign branch_o    = ctrl.branch;
  assign wrpc_o      = ctrl.wrpc;
  assign sela_o      = ctrl.sela;
  assign selb_o      = ctrl.selb;
  assign wracc_o     = ctrl.wracc;
  assign op_o        = ctrl.op;
  assign wrram_o     = ctrl.wrram;
  assign ret_o       = ctrl.ret;
  assign illegal_o   = ctrl.illegal;
  assign halted_o    = (state_q == ST_HALT);
  assign stack_err_o = err_q;

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Parametrised, multi-cycle successor of the BIP-2 single-cycle decoder.
- Sequences each instruction through FETCH and EXEC states and drives the same datapath controls: branch, wrpc, sela, selb, wracc, op, wrram.
- Adds CALL/RET backed by an internal hardware return-address stack, a sticky halt state, and illegal-opcode and stack-error reporting.
- Sits between instruction memory (opcode), the ACC flag logic (n, z) and the BIP datapath/PC mux.

Parameters:
ADDR_W, 11, width of program addresses (PC and stack entries)
STACK_DEPTH, 4, number of return-address entries; must be >= 1
OPC_W, 5, opcode width; fixed at 5, exposed for the shared package

Ports:
clock_i  input  1  system clock, rising edge
reset_n_i  input  1  synchronous, active-low reset
opcode_i  input  OPC_W  opcode from instruction memory, valid in FETCH
n_i  input  1  ACC negative flag
z_i  input  1  ACC zero flag
pc_next_i  input  ADDR_W  PC+1 from datapath, pushed on CALL
branch_o  output  1  PC mux selects branch target
wrpc_o  output  1  PC write enable
sela_o  output  2  ACC source: 00 memory, 01 immediate, 10 ALU
selb_o  output  1  ALU B operand: 0 memory, 1 immediate
wracc_o  output  1  ACC write enable
op_o  output  1  ALU op: 0 add, 1 sub
wrram_o  output  1  data RAM write enable
ret_o  output  1  PC mux selects stack_top_o (overrides branch_o)
stack_top_o  output  ADDR_W  current top-of-stack return address
halted_o  output  1  core halted
illegal_o  output  1  one-cycle pulse: undefined opcode executed
stack_err_o  output  1  sticky: overflow or underflow occurred

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset state when reset_n_i=0 at a rising edge: state=FETCH, stack pointer=0, IR=0, stack_err_o=0, halted_o=0, all control outputs=0, stack_top_o=0. Reset mid-instruction aborts the instruction; no write enable is asserted in the following cycle.
- FSM states: FETCH, EXEC, HALT.
  - FETCH -> EXEC always. At the FETCH edge, opcode_i, n_i and z_i are latched into IR and flag registers.
  - EXEC -> FETCH for every instruction except HLT and stack error, which go to HALT.
  - HALT is left only by reset.
- Outputs are Moore-decoded from state and IR.
  - Every control output is 0 in FETCH and HALT, so each instruction takes exactly 2 cycles.
  - All enables pulse for exactly the one EXEC cycle.
- EXEC decode (wrpc_o=1 for every non-HLT opcode):
  - HLT 00000: no enables; next state HALT; halted_o=1 from the following cycle.
  - STO 00001: wrram_o=1.
  - LD 00010: wracc_o=1, sela_o=00.
  - LDI 00011: wracc_o=1, sela_o=01.
  - ADD 00100 / ADDI 00101: wracc_o=1, sela_o=10, op_o=0, selb_o=0 / 1.
  - SUB 00110 / SUBI 00111: as ADD/ADDI, but op_o=1.
  - Branches, branch_o=condition on the latched flags:
    - BEQ 01000: z.
    - BNE 01001: !z.
    - BGT 01010: !n & !z.
    - BGE 01011: !n.
    - BLT 01100: n.
    - BLE 01101: n | z.
  - JMP 01110: branch_o=1.
  - CALL 10000: branch_o=1; push pc_next_i at the EXEC edge.
  - RET 10001: ret_o=1; pop at the EXEC edge.
  - Any other opcode: wrpc_o=1 only (NOP), illegal_o=1 for that cycle.
- Stack behaviour:
  - Storage is a LIFO of STACK_DEPTH entries with a pointer 0..STACK_DEPTH.
  - stack_top_o = entry[sp-1], or 0 when empty; it updates the cycle after a push/pop.
- Stack boundary conditions:
  - CALL when full: no push, all EXEC outputs 0, stack_err_o<=1, next state HALT.
  - RET when empty: ret_o=0, wrpc_o=0, stack_err_o<=1, next state HALT.
  - stack_err_o is cleared only by reset.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams: OP_HLT..OP_RET;
  - sela encodings: SELA_MEM, SELA_IMM, SELA_ALU;
  - state enum: ST_FETCH, ST_EXEC, ST_HALT;
  - OPC_W.
- One sub-module, bip_ret_stack: parameters ADDR_W and STACK_DEPTH; ports clock_i, reset_n_i, push_i, pop_i, data_i, top_o, full_o, empty_o.
  - push_i and pop_i are never asserted together.

Test Plan:
- Reset, then LDI: reset_n_i=0 for 2 cycles, then opcode_i=00011 -> outputs all 0 in FETCH; in EXEC wracc_o=1, sela_o=01, wrpc_o=1 for exactly one cycle.
- Branch sweep: for opcodes 01000..01101 with (n,z) in {00,01,10,11} -> branch_o matches the condition table in all 24 cases; wrpc_o=1 in each EXEC.
- CALL/RET: STACK_DEPTH=4; CALL with pc_next_i=0x005, then CALL with 0x00A -> stack_top_o=0x00A; RET -> ret_o=1 while the top is 0x00A; after the pop stack_top_o=0x005.
- Overflow: 5 consecutive CALLs at depth 4 -> 5th EXEC has all outputs 0; stack_err_o=1; halted_o=1 thereafter.
- Underflow: RET on an empty stack -> ret_o=0, wrpc_o=0, stack_err_o=1, HALT.
- HLT and illegal opcodes:
  - opcode 10111 -> illegal_o pulses once, wrpc_o=1;
  - HLT -> halted_o=1 and no enables for 20 cycles;
  - reset during HALT -> FETCH, halted_o=0.
